// File: rtl/add_pkg.sv
// Shared constants and helpers for the round-robin shared-adder arbiter.
package add_pkg;

    localparam int OPW      = 8;
    localparam int NREQ_DEF = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int clog2_id(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/add8b.sv
// Plain 8-bit adder with carry-in tied to zero and carry-out exposed.
module add8b
    import add_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic [OPW-1:0] s,
    output logic           c_out
);

    assign {c_out, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after ptr, one-hot plus index.
module rr_pick
    import add_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2_id(NREQ)
)
(
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic found;
    int   c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(ptr) + k) % NREQ;
            if (en && !found && req[c]) begin
                gnt[c] = 1'b1;
                idx    = IDW'(c);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add8b_arbiter.sv
// Round-robin arbiter sharing one add8b among NREQ requesters; registered result
// with valid/ready handshake.
module add8b_arbiter
    import add_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = clog2_id(NREQ)
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*OPW-1:0] x_in,
    input  logic [NREQ*OPW-1:0] y_in,
    output logic [NREQ-1:0]     gnt,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic [OPW-1:0]      res_s,
    output logic                res_cout
);

    logic           can_issue;
    logic           pick_en;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] idx_p0;
    logic [OPW-1:0] x_p0;
    logic [OPW-1:0] y_p0;
    logic [OPW-1:0] sum_p0;
    logic           cout_p0;

    // A new add may issue whenever the result slot is empty or drains this edge.
    assign can_issue = !res_valid || res_ready;
    assign pick_en   = can_issue && !rst;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .en  (pick_en),
        .gnt (gnt),
        .idx (idx_p0)
    );

    always_comb begin
        x_p0 = x_in[int'(idx_p0)*OPW +: OPW];
        y_p0 = y_in[int'(idx_p0)*OPW +: OPW];
    end

    add8b u_add (
        .a     (x_p0),
        .b     (y_p0),
        .s     (sum_p0),
        .c_out (cout_p0)
    );

    // ---- stage p0 -> result registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_s     <= '0;
            res_cout  <= 1'b0;
            rr_ptr    <= IDW'(NREQ - 1);
        end else if (|gnt) begin
            res_valid <= 1'b1;
            res_id    <= idx_p0;
            res_s     <= sum_p0;
            res_cout  <= cout_p0;
            rr_ptr    <= idx_p0;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add8b_arbiter.sv
// Self-checking bench for add8b_arbiter: directed vector table, hand sequences, random run.
module tb_add8b_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] x_in;
    logic [NREQ*8-1:0] y_in;
    logic [NREQ-1:0]   gnt;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_id;
    logic [7:0]        res_s;
    logic              res_cout;

    add8b_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_s     (res_s),
        .res_cout  (res_cout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] opx [NREQ];
    logic [7:0] opy [NREQ];

    // Reference model state
    int m_valid, m_id, m_s, m_c, m_ptr;

    typedef struct {
        logic [3:0] req;
        logic [7:0] x;
        logic [7:0] y;
        logic       rdy;
        logic [3:0] e_gnt;
        logic       e_v;
        logic [1:0] e_id;
        logic [7:0] e_s;
        logic       e_c;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            x_in[i*8 +: 8] = opx[i];
            y_in[i*8 +: 8] = opy[i];
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_s = 0; m_c = 0; m_ptr = NREQ - 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin opx[i] = 8'h00; opy[i] = 8'h00; end
        pack_ops();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Expected grant: first pending requester after the last one served, if the slot is free.
    task automatic model_pick(output logic [3:0] g, output int gi);
        g = '0;
        gi = 0;
        if (!m_valid || res_ready) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_ptr + k) % NREQ;
                if (req[c]) begin
                    g[c] = 1'b1;
                    gi = c;
                    break;
                end
            end
        end
    endtask

    task automatic model_edge(input logic [3:0] g, input int gi, input logic rdy);
        int sum;
        if (g != 0) begin
            sum = int'(opx[gi]) + int'(opy[gi]);
            m_s = sum % 256;
            m_c = (sum > 255) ? 1 : 0;
            m_id = gi;
            m_valid = 1;
            m_ptr = gi;
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0;
        end
    endtask

    initial begin
        logic [3:0] g_exp;
        int gi;
        int wt [NREQ];
        logic [3:0] prev_g;

        // ---------------- table-driven directed vectors ----------------
        tbl[0] = '{4'b0100, 8'h12, 8'h34, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h46, 1'b0};
        tbl[1] = '{4'b0001, 8'hFF, 8'h01, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h00, 1'b1};
        tbl[2] = '{4'b0010, 8'h80, 8'h80, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h00, 1'b1};
        tbl[3] = '{4'b0000, 8'h55, 8'h55, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h00, 1'b1};
        tbl[4] = '{4'b1111, 8'h07, 8'h09, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h10, 1'b0};
        tbl[5] = '{4'b1111, 8'h33, 8'h44, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h10, 1'b0};
        tbl[6] = '{4'b1111, 8'hF0, 8'h20, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h10, 1'b1};
        tbl[7] = '{4'b1001, 8'h01, 8'h02, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h03, 1'b0};

        do_reset();
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_s", int'(res_s), 0);
        chk("rst_id", int'(res_id), 0);
        chk("rst_cout", int'(res_cout), 0);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NREQ; i++) begin opx[i] = tbl[v].x; opy[i] = tbl[v].y; end
            pack_ops();
            req = tbl[v].req;
            res_ready = tbl[v].rdy;
            #1;
            chk($sformatf("tbl%0d_gnt", v), int'(gnt), int'(tbl[v].e_gnt));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", v), int'(res_valid), int'(tbl[v].e_v));
            chk($sformatf("tbl%0d_id", v), int'(res_id), int'(tbl[v].e_id));
            chk($sformatf("tbl%0d_s", v), int'(res_s), int'(tbl[v].e_s));
            chk($sformatf("tbl%0d_cout", v), int'(res_cout), int'(tbl[v].e_c));
            @(negedge clk);
        end

        // ---------------- async reset with a result pending ----------------
        req = 4'b0010; opx[1] = 8'hAA; opy[1] = 8'h11; pack_ops(); res_ready = 1'b1;
        @(posedge clk); #1;
        chk("pre_rst_valid", int'(res_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(res_valid), 0);
        chk("arst_s", int'(res_s), 0);
        chk("arst_id", int'(res_id), 0);
        chk("arst_cout", int'(res_cout), 0);
        chk("arst_gnt", int'(gnt), 0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        #1;
        chk("post_rst_gnt", int'(gnt), 'b0001);

        // ---------------- round-robin sweep, no bubbles ----------------
        for (int i = 0; i < NREQ; i++) begin opx[i] = 8'(i * 16); opy[i] = 8'(i + 1); end
        pack_ops();
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("rr%0d_gnt", n), int'(gnt), 1 << (n % NREQ));
            @(posedge clk); #1;
            chk($sformatf("rr%0d_valid", n), int'(res_valid), 1);
            chk($sformatf("rr%0d_id", n), int'(res_id), n % NREQ);
            chk($sformatf("rr%0d_s", n), int'(res_s), (n % NREQ) * 16 + (n % NREQ) + 1);
            @(negedge clk); #1;
        end

        // ---------------- backpressure ----------------
        do_reset();
        req = 4'b0010; opx[1] = 8'h21; opy[1] = 8'h12; pack_ops(); res_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp_load_id", int'(res_id), 1);
        @(negedge clk);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk($sformatf("bp%0d_gnt", n), int'(gnt), 0);
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", n), int'(res_valid), 1);
            chk($sformatf("bp%0d_id", n), int'(res_id), 1);
            chk($sformatf("bp%0d_s", n), int'(res_s), 'h33);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_gnt", int'(gnt), 'b0100);
        @(negedge clk);

        // ---------------- randomized run against the model ----------------
        do_reset();
        prev_g = '0;
        for (int i = 0; i < NREQ; i++) wt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (prev_g[i] || !req[i]) begin
                    req[i] = ($urandom_range(0, 2) == 0);
                    opx[i] = 8'($urandom);
                    opy[i] = 8'($urandom);
                    wt[i] = 0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                    wt[i] = 0;
                end
            end
            pack_ops();
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            model_pick(g_exp, gi);
            chk("rnd_gnt", int'(gnt), int'(g_exp));
            if (g_exp != 0) begin
                chk("rnd_starve", (wt[gi] < NREQ) ? 1 : 0, 1);
                for (int i = 0; i < NREQ; i++) begin
                    if (i == gi) wt[i] = 0;
                    else if (req[i]) wt[i]++;
                end
            end
            @(posedge clk);
            model_edge(g_exp, gi, res_ready);
            prev_g = g_exp;
            #1;
            chk("rnd_valid", int'(res_valid), m_valid);
            if (m_valid != 0) begin
                chk("rnd_id", int'(res_id), m_id);
                chk("rnd_s", int'(res_s), m_s);
                chk("rnd_cout", int'(res_cout), m_c);
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
